// File: rtl/csr_wr_pipe_pkg.sv
// csr_wr_pipe_pkg
//   Shared types and constants for the CSR write pipeline.
//   csr_pend_t    : one in-flight CSR write slot {valid, wr, ill, addr, data}
//   CSR_PEND_DEPTH: default number of pending slots between EXE and commit
//   pend_is_live(): slot holds a legal CSR write (commits and forwards)
package csr_wr_pipe_pkg;

  localparam int CSR_RSZ        = 32;
  localparam int CSR_AW         = 12;
  localparam int CSR_PEND_DEPTH = 2;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              ill;
    logic [CSR_AW-1:0] addr;
    logic [CSR_RSZ-1:0] data;
  } csr_pend_t;

  localparam csr_pend_t CSR_PEND_EMPTY = '0;

  // A slot only commits or forwards when it is a valid, legal write.
  function automatic logic pend_is_live(input csr_pend_t s);
    return s.valid && s.wr && !s.ill;
  endfunction

endpackage

// File: rtl/csr_wr_pipe_if.sv
// csr_wr_pipe_if
//   Bundles the EXE-side request, forwarding query, WB commit and status
//   signals of csr_wr_pipe.
//   master : the surrounding core (drives EXE request, flush, query, wb_ack)
//   slave  : csr_wr_pipe (drives ready, forwarding result, commit, status)
interface csr_wr_pipe_if
  import csr_wr_pipe_pkg::*;
#(
  parameter int RSZ = CSR_RSZ
) ();

  logic              exe_valid;
  logic              exe_ready;
  logic              exe_csr_wr;
  logic [CSR_AW-1:0] exe_csr_addr;
  logic [RSZ-1:0]    exe_csr_wr_data;
  logic              exe_ill;
  logic              flush;
  logic [CSR_AW-1:0] q_csr_addr;
  logic              q_hit;
  logic [RSZ-1:0]    q_data;
  logic              wb_csr_wr;
  logic [CSR_AW-1:0] wb_csr_addr;
  logic [RSZ-1:0]    wb_csr_wr_data;
  logic              wb_ack;
  logic              wb_ill;
  logic [CSR_AW-1:0] wb_ill_addr;
  logic [2:0]        pend_cnt;
  logic [31:0]       commit_cnt;

  modport master (
    output exe_valid, exe_csr_wr, exe_csr_addr, exe_csr_wr_data, exe_ill,
    output flush, q_csr_addr, wb_ack,
    input  exe_ready, q_hit, q_data, wb_csr_wr, wb_csr_addr, wb_csr_wr_data,
    input  wb_ill, wb_ill_addr, pend_cnt, commit_cnt
  );

  modport slave (
    input  exe_valid, exe_csr_wr, exe_csr_addr, exe_csr_wr_data, exe_ill,
    input  flush, q_csr_addr, wb_ack,
    output exe_ready, q_hit, q_data, wb_csr_wr, wb_csr_addr, wb_csr_wr_data,
    output wb_ill, wb_ill_addr, pend_cnt, commit_cnt
  );

endinterface

// File: rtl/csr_wr_pipe_fwd_mux.sv
// csr_fwd_mux
//   Combinational forwarding lookup over the pending CSR write slots.
//   slots_i  : pending slots, index 0 is the youngest (MEM), DEPTH-1 is WB
//   q_addr_i : queried CSR address
//   q_hit_o  : some legal pending write targets q_addr_i
//   q_data_o : data of the youngest such write, 0 when there is no hit
module csr_fwd_mux
  import csr_wr_pipe_pkg::*;
#(
  parameter int DEPTH = CSR_PEND_DEPTH,
  parameter int RSZ   = CSR_RSZ
) (
  input  csr_pend_t [DEPTH-1:0] slots_i,
  input  logic [CSR_AW-1:0]     q_addr_i,
  output logic                  q_hit_o,
  output logic [RSZ-1:0]        q_data_o
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = pend_is_live(slots_i[gi]) && (slots_i[gi].addr == q_addr_i);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index is the last
  // one written and therefore wins.
  always_comb begin
    q_hit_o  = |match;
    q_data_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        q_data_o = slots_i[i].data;
      end
    end
  end

endmodule

// File: rtl/csr_wr_pipe.sv
// csr_wr_pipe
//   Carries CSR writes from EXE through MEM to WB, commits them to the CSR
//   file with a request/ack handshake, forwards the youngest pending value
//   for a queried address and reports illegal accesses in program order.
//   clk_in   : clock
//   reset_in : asynchronous reset, active-low
//   bus      : csr_wr_pipe_if.slave (EXE request, flush, forwarding query,
//              WB commit, illegal-access report, pend_cnt, commit_cnt)
//   RSZ must equal CSR_RSZ, the data width of the slot type in the package.
module csr_wr_pipe
  import csr_wr_pipe_pkg::*;
#(
  parameter int RSZ   = CSR_RSZ,
  parameter int DEPTH = CSR_PEND_DEPTH   // 2..4
) (
  input  logic         clk_in,
  input  logic         reset_in,
  csr_wr_pipe_if.slave bus
);

  csr_pend_t [DEPTH-1:0] slot_q, slot_d;
  csr_pend_t             wb_slot;
  csr_pend_t             exe_entry;
  logic                  wb_live;
  logic                  adv;
  logic                  commit_fire;
  logic [31:0]           commit_cnt_q, commit_cnt_d;
  logic [2:0]            pend_cnt_q, pend_cnt_d;

  assign wb_slot = slot_q[DEPTH-1];
  assign wb_live = pend_is_live(wb_slot);

  // Only an un-acked legal write in WB can hold the pipe; illegal or
  // non-writing entries retire on their first WB cycle.
  assign adv         = !(wb_live && !bus.wb_ack);
  assign commit_fire = wb_live && bus.wb_ack;

  always_comb begin
    exe_entry = CSR_PEND_EMPTY;
    if (bus.exe_valid) begin
      exe_entry.valid = 1'b1;
      exe_entry.wr    = bus.exe_csr_wr;
      exe_entry.ill   = bus.exe_ill;
      exe_entry.addr  = bus.exe_csr_addr;
      exe_entry.data  = bus.exe_csr_wr_data;
    end
  end

  // Flush empties every slot, including WB: an acked WB write still counts
  // through commit_fire, an un-acked one is dropped. EXE is not loaded.
  always_comb begin
    slot_d = slot_q;
    if (bus.flush) begin
      slot_d = '0;
    end else if (adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0] = exe_entry;
    end
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + 3'(pend_is_live(slot_d[i]));
    end
  end

  assign commit_cnt_d = commit_cnt_q + 32'(commit_fire);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      slot_q       <= '0;
      pend_cnt_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      slot_q       <= slot_d;
      pend_cnt_q   <= pend_cnt_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign bus.exe_ready      = adv;
  assign bus.wb_csr_wr      = wb_live;
  assign bus.wb_csr_addr    = wb_live ? wb_slot.addr : '0;
  assign bus.wb_csr_wr_data = wb_live ? wb_slot.data : '0;
  assign bus.wb_ill         = wb_slot.valid && wb_slot.ill;
  assign bus.wb_ill_addr    = (wb_slot.valid && wb_slot.ill) ? wb_slot.addr : '0;
  assign bus.pend_cnt       = pend_cnt_q;
  assign bus.commit_cnt     = commit_cnt_q;

  csr_fwd_mux #(
    .DEPTH (DEPTH),
    .RSZ   (RSZ)
  ) u_fwd (
    .slots_i  (slot_q),
    .q_addr_i (bus.q_csr_addr),
    .q_hit_o  (bus.q_hit),
    .q_data_o (bus.q_data)
  );

endmodule
